// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the cache-side memory port arbiter.
// Includes FSM states, transfer size codes and the request record.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT_I = 2'd1;
    localparam logic [1:0] ST_GRANT_D = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [3:0] SEL_WORD = 4'b1111;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic [3:0]  sel;
        logic        write;
    } req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and axi_interface-side signals of the memory port arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_port_arbiter_if;

    logic        i_strobe;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;

    logic        d_strobe;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [1:0]  d_size;
    logic [3:0]  d_sel;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;

    logic [31:0] mem_a;
    logic        mem_access;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [3:0]  mem_sel;
    logic [31:0] mem_st_data;
    logic [31:0] mem_data;
    logic        mem_ready;

    modport slave (
        input  i_strobe, i_addr, d_strobe, d_rw, d_addr, d_size, d_sel, d_wdata,
               mem_data, mem_ready,
        output i_ready, i_rdata, d_ready, d_rdata,
               mem_a, mem_access, mem_write, mem_size, mem_sel, mem_st_data
    );

    modport master (
        output i_strobe, i_addr, d_strobe, d_rw, d_addr, d_size, d_sel, d_wdata,
               mem_data, mem_ready,
        input  i_ready, i_rdata, d_ready, d_rdata,
               mem_a, mem_access, mem_write, mem_size, mem_sel, mem_st_data
    );

endinterface

// File: rtl/mem_port_arbiter_arb_req_latch.sv
// Selects the winning requester's fields and captures them at grant time,
// so the memory request stays stable for the whole transaction.
module arb_req_latch
    import mem_port_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic        sel_inst,
    input  logic [31:0] i_addr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_sel,
    input  logic        d_rw,
    output req_t        req
);

    req_t next_req;

    // Instruction fetches are always full-word reads.
    always_comb begin
        next_req = '0;
        if (sel_inst) begin
            next_req.addr  = i_addr;
            next_req.wdata = 32'h0;
            next_req.size  = SZ_WORD;
            next_req.sel   = SEL_WORD;
            next_req.write = 1'b0;
        end else begin
            next_req.addr  = d_addr;
            next_req.wdata = d_wdata;
            next_req.size  = d_size;
            next_req.sel   = d_sel;
            next_req.write = d_rw;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            req <= '0;
        else if (capture)
            req <= next_req;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Registered arbiter sharing the axi_interface cache port between the i-cache and d-cache.
// Data side wins by default; a skip counter forces an inst grant after MAX_SKIP losses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_SKIP = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus,
    output logic              busy
);

    localparam logic [3:0] SKIP_LIMIT = 4'(MAX_SKIP);

    logic [1:0] state;
    logic [1:0] next_state;
    logic [3:0] skip_cnt;
    logic       grant_i;
    logic       grant_d;
    logic       in_grant_i;
    logic       in_grant_d;
    req_t       req;

    always_comb begin
        grant_i = (state == ST_IDLE) && bus.i_strobe &&
                  (!bus.d_strobe || (skip_cnt >= SKIP_LIMIT));
        grant_d = (state == ST_IDLE) && bus.d_strobe && !grant_i;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (grant_i)
                    next_state = ST_GRANT_I;
                else if (grant_d)
                    next_state = ST_GRANT_D;
            end
            ST_GRANT_I, ST_GRANT_D: begin
                if (bus.mem_ready)
                    next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // skip_cnt counts only data wins that actually made the inst side wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            skip_cnt <= 4'd0;
        end else begin
            state <= next_state;
            if (grant_i)
                skip_cnt <= 4'd0;
            else if (grant_d && bus.i_strobe && (skip_cnt < SKIP_LIMIT))
                skip_cnt <= skip_cnt + 4'd1;
        end
    end

    arb_req_latch u_req_latch (
        .clk      (clk),
        .rst      (rst),
        .capture  (grant_i || grant_d),
        .sel_inst (grant_i),
        .i_addr   (bus.i_addr),
        .d_addr   (bus.d_addr),
        .d_wdata  (bus.d_wdata),
        .d_size   (bus.d_size),
        .d_sel    (bus.d_sel),
        .d_rw     (bus.d_rw),
        .req      (req)
    );

    assign busy       = (state != ST_IDLE);
    assign in_grant_i = (state == ST_GRANT_I);
    assign in_grant_d = (state == ST_GRANT_D);

    // Request fields are masked outside a grant so IDLE shows an all-zero port.
    assign bus.mem_access  = busy;
    assign bus.mem_a       = busy ? req.addr  : 32'h0;
    assign bus.mem_write   = busy ? req.write : 1'b0;
    assign bus.mem_size    = busy ? req.size  : 2'd0;
    assign bus.mem_sel     = busy ? req.sel   : 4'd0;
    assign bus.mem_st_data = busy ? req.wdata : 32'h0;

    assign bus.i_ready = in_grant_i && bus.mem_ready;
    assign bus.d_ready = in_grant_d && bus.mem_ready;
    assign bus.i_rdata = bus.i_ready ? bus.mem_data : 32'h0;
    assign bus.d_rdata = bus.d_ready ? bus.mem_data : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions plus
// hand sequences for starvation, withdrawal and mid-flight reset.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    typedef struct {
        logic        is;
        logic        ds;
        logic        rw;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] wd;
        logic [1:0]  sz;
        logic [3:0]  sel;
        logic [31:0] md;
        int          g;      // 0 none, 1 inst, 2 data
        logic [31:0] ea;
        logic        ew;
        logic [1:0]  esz;
        logic [3:0]  esel;
        logic [31:0] ewd;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   tests = 0;
    int   fails = 0;
    vec_t vecs[7];
    int   exp_seq[10];
    int   got;
    int   waited;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MAX_SKIP(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_strobe  = 1'b0;
        bus.i_addr    = 32'h0;
        bus.d_strobe  = 1'b0;
        bus.d_rw      = 1'b0;
        bus.d_addr    = 32'h0;
        bus.d_size    = 2'd0;
        bus.d_sel     = 4'd0;
        bus.d_wdata   = 32'h0;
        bus.mem_data  = 32'h0;
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        //           is  ds  rw  ia            da            wd            sz    sel      md            g  ea            ew  esz   esel     ewd
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'hBFC00000, 32'h0, 32'h0, 2'd0, 4'h0, 32'h3C080001,
                    1, 32'hBFC00000, 1'b0, 2'd2, 4'hF, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h80001003, 32'hAB000000, 2'd0, 4'b1000, 32'h0,
                    2, 32'h80001003, 1'b1, 2'd0, 4'b1000, 32'hAB000000};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h80000010, 32'h12345678, 2'd2, 4'hF, 32'hDEADBEEF,
                    2, 32'h80000010, 1'b0, 2'd2, 4'hF, 32'h12345678};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 4'h0, 32'h55555555,
                    0, 32'h0, 1'b0, 2'd0, 4'h0, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h00400000, 32'h10000000, 32'h0, 2'd1, 4'b0011, 32'hCAFE0000,
                    2, 32'h10000000, 1'b0, 2'd1, 4'b0011, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h00400004, 32'h0, 32'h0, 2'd0, 4'h0, 32'h11112222,
                    1, 32'h00400004, 1'b0, 2'd2, 4'hF, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h80000002, 32'hBEEF0000, 2'd1, 4'b1100, 32'h0,
                    2, 32'h80000002, 1'b1, 2'd1, 4'b1100, 32'hBEEF0000};
        exp_seq = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_access", bus.mem_access, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_a", bus.mem_a, 32'h0);
        chk("rst_i_ready", bus.i_ready, 1'b0);
        chk("rst_d_ready", bus.d_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            bus.i_strobe = vecs[i].is;
            bus.i_addr   = vecs[i].ia;
            bus.d_strobe = vecs[i].ds;
            bus.d_rw     = vecs[i].rw;
            bus.d_addr   = vecs[i].da;
            bus.d_size   = vecs[i].sz;
            bus.d_sel    = vecs[i].sel;
            bus.d_wdata  = vecs[i].wd;
            @(posedge clk); #1;
            // Requester fields change after the grant; the port must not follow.
            bus.i_addr  = ~vecs[i].ia;
            bus.d_addr  = ~vecs[i].da;
            bus.d_wdata = ~vecs[i].wd;
            bus.d_sel   = ~vecs[i].sel;
            bus.d_rw    = ~vecs[i].rw;
            bus.d_size  = 2'd3;
            @(negedge clk);
            if (vecs[i].g == 0) begin
                chk($sformatf("v%0d_idle_access", i), bus.mem_access, 1'b0);
                bus.mem_ready = 1'b1;
                bus.mem_data  = vecs[i].md;
                #1;
                chk($sformatf("v%0d_spur_i_ready", i), bus.i_ready, 1'b0);
                chk($sformatf("v%0d_spur_d_ready", i), bus.d_ready, 1'b0);
                chk($sformatf("v%0d_spur_d_rdata", i), bus.d_rdata, 32'h0);
                @(posedge clk); #1;
                bus.mem_ready = 1'b0;
                @(negedge clk);
                chk($sformatf("v%0d_spur_busy", i), busy, 1'b0);
            end else begin
                chk($sformatf("v%0d_access", i), bus.mem_access, 1'b1);
                chk($sformatf("v%0d_busy", i), busy, 1'b1);
                chk($sformatf("v%0d_mem_a", i), bus.mem_a, vecs[i].ea);
                chk($sformatf("v%0d_write", i), bus.mem_write, vecs[i].ew);
                chk($sformatf("v%0d_size", i), bus.mem_size, vecs[i].esz);
                chk($sformatf("v%0d_sel", i), bus.mem_sel, vecs[i].esel);
                chk($sformatf("v%0d_st_data", i), bus.mem_st_data, vecs[i].ewd);
                chk($sformatf("v%0d_early_ready", i), {bus.i_ready, bus.d_ready}, 2'b00);
                @(posedge clk); #1;
                bus.mem_ready = 1'b1;
                bus.mem_data  = vecs[i].md;
                @(negedge clk);
                chk($sformatf("v%0d_i_ready", i), bus.i_ready, vecs[i].g == 1);
                chk($sformatf("v%0d_d_ready", i), bus.d_ready, vecs[i].g == 2);
                chk($sformatf("v%0d_i_rdata", i), bus.i_rdata, (vecs[i].g == 1) ? vecs[i].md : 32'h0);
                chk($sformatf("v%0d_d_rdata", i), bus.d_rdata, (vecs[i].g == 2) ? vecs[i].md : 32'h0);
                @(posedge clk); #1;
                bus.mem_ready = 1'b0;
                bus.i_strobe  = 1'b0;
                bus.d_strobe  = 1'b0;
                @(negedge clk);
                chk($sformatf("v%0d_bubble_access", i), bus.mem_access, 1'b0);
                chk($sformatf("v%0d_bubble_mem_a", i), bus.mem_a, 32'h0);
            end
        end

        // Both requesters held continuously: expect D,D,D,D,I repeating.
        @(posedge clk); #1;
        bus.i_strobe = 1'b1;
        bus.i_addr   = 32'h00001000;
        bus.d_strobe = 1'b1;
        bus.d_rw     = 1'b0;
        bus.d_addr   = 32'h00002000;
        bus.d_size   = 2'd2;
        bus.d_sel    = 4'hF;
        for (int k = 0; k < 10; k++) begin
            waited = 0;
            @(negedge clk);
            while (!bus.mem_access && waited < 6) begin
                @(negedge clk);
                waited++;
            end
            chk($sformatf("starve%0d_granted", k), bus.mem_access, 1'b1);
            got = (bus.mem_a == 32'h00001000) ? 1 : ((bus.mem_a == 32'h00002000) ? 2 : 0);
            chk($sformatf("starve%0d_winner", k), got, exp_seq[k]);
            @(posedge clk); #1;
            bus.mem_ready = 1'b1;
            bus.mem_data  = 32'(k);
            @(negedge clk);
            chk($sformatf("starve%0d_ready", k), {bus.i_ready, bus.d_ready},
                (exp_seq[k] == 1) ? 2'b10 : 2'b01);
            @(posedge clk); #1;
            bus.mem_ready = 1'b0;
        end
        bus.i_strobe = 1'b0;
        bus.d_strobe = 1'b0;

        // Inst strobe pulses while data owns the port: no inst transaction follows.
        @(posedge clk); #1;
        bus.d_strobe = 1'b1;
        bus.d_addr   = 32'h00003000;
        @(posedge clk); #1;
        bus.i_strobe = 1'b1;
        bus.i_addr   = 32'h00004000;
        @(posedge clk); #1;
        bus.i_strobe = 1'b0;
        @(negedge clk);
        chk("wd_before_mem_a", bus.mem_a, 32'h00003000);
        @(posedge clk); #1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("wd_before_ready", {bus.i_ready, bus.d_ready}, 2'b01);
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        bus.d_strobe  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("wd_before_quiet%0d", k), bus.mem_access, 1'b0);
        end

        // Inst strobe withdrawn after grant: transaction still completes.
        @(posedge clk); #1;
        bus.i_strobe = 1'b1;
        bus.i_addr   = 32'h00005000;
        @(posedge clk); #1;
        bus.i_strobe = 1'b0;
        @(negedge clk);
        chk("wd_after_access", bus.mem_access, 1'b1);
        chk("wd_after_mem_a", bus.mem_a, 32'h00005000);
        @(posedge clk);
        @(negedge clk);
        chk("wd_after_hold", bus.mem_access, 1'b1);
        @(posedge clk); #1;
        bus.mem_ready = 1'b1;
        bus.mem_data  = 32'hA5A5A5A5;
        @(negedge clk);
        chk("wd_after_i_ready", bus.i_ready, 1'b1);
        chk("wd_after_i_rdata", bus.i_rdata, 32'hA5A5A5A5);
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("wd_after_done", bus.mem_access, 1'b0);

        // Asynchronous reset in the middle of a data transaction.
        @(posedge clk); #1;
        bus.d_strobe = 1'b1;
        bus.d_addr   = 32'h00006000;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rmid_busy_before", busy, 1'b1);
        #1;
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        chk("rmid_access", bus.mem_access, 1'b0);
        chk("rmid_busy", busy, 1'b0);
        chk("rmid_d_ready", bus.d_ready, 1'b0);
        chk("rmid_mem_a", bus.mem_a, 32'h0);
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.mem_ready = 1'b0;
        bus.d_strobe  = 1'b0;
        bus.i_strobe  = 1'b1;
        bus.i_addr    = 32'h00007000;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rpost_access", bus.mem_access, 1'b1);
        chk("rpost_mem_a", bus.mem_a, 32'h00007000);
        chk("rpost_size", bus.mem_size, 2'd2);
        @(posedge clk); #1;
        bus.mem_ready = 1'b1;
        bus.mem_data  = 32'h0BADF00D;
        @(negedge clk);
        chk("rpost_i_ready", bus.i_ready, 1'b1);
        chk("rpost_i_rdata", bus.i_rdata, 32'h0BADF00D);
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        bus.i_strobe  = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
